tlk2711_axi_mem_resp: RTL and testbench

- Parametrised AXI4 slave responder for the tlk2711_top DMA master ports. Bench-side successor to the ad hoc read/write handshake logic in the tlk2711 benches.
- Read side: queues multiple outstanding AR requests, applies a configurable first-beat latency, and returns pattern data with correct RID/RLAST.
- Write side: accepts one AW at a time, checks W beat count against AWLEN, and returns B with OKAY or SLVERR.
- Synthesisable, so it can also act as a loopback DMA target on hardware.

---
 rtl/tlk2711_axi_pkg.sv | 15 +
 rtl/tlk2711_axi_mem_resp_if.sv | 52 +++++
 rtl/tlk2711_sync_fifo.sv | 43 ++++
 rtl/tlk2711_axi_mem_resp.sv | 181 ++++++++++++++++++
 tb/tb_tlk2711_axi_mem_resp.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlk2711_axi_pkg.sv
// Shared constants for the tlk2711 AXI memory responder: response codes and FSM state encodings.
package tlk2711_axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t R_IDLE  = 2'd0;
  localparam fsm_state_t R_WAIT  = 2'd1;
  localparam fsm_state_t R_BURST = 2'd2;

  localparam fsm_state_t W_IDLE  = 2'd0;
  localparam fsm_state_t W_DATA  = 2'd1;
  localparam fsm_state_t W_RESP  = 2'd2;
endpackage

// File: rtl/tlk2711_axi_mem_resp_if.sv
// AXI4 read/write channel bundle between the tlk2711 DMA master and the memory responder.
interface tlk2711_axi_mem_resp_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/tlk2711_sync_fifo.sv
// Small first-word-fall-through FIFO holding outstanding read requests.
module tlk2711_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/tlk2711_axi_mem_resp.sv
// AXI4 slave responder for the tlk2711 DMA ports: queued reads with latency and pattern data,
// single-outstanding writes with beat-count checking. Optional random stalls: TLK_AXI_RAND_STALL_EN.
module tlk2711_axi_mem_resp
  import tlk2711_axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 48,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    AR_DEPTH   = 4,
  parameter int                    RD_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] DATA_INIT  = 1,
  parameter logic [DATA_WIDTH-1:0] DATA_INC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  tlk2711_axi_mem_resp_if.slave s_axi,
  output logic [31:0]           o_rd_beats,
  output logic [31:0]           o_wr_beats,
  output logic                  o_wr_err
);
  localparam int QW = ID_WIDTH + 8;
  localparam int CW = $clog2(AR_DEPTH) + 1;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  logic r_stall, w_stall;

`ifdef TLK_AXI_RAND_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign r_stall = lfsr[0];
  assign w_stall = lfsr[1];
`else
  assign r_stall = 1'b0;
  assign w_stall = 1'b0;
`endif

  // ---------------- AR queue ----------------
  logic          ar_push, ar_pop, q_full, q_empty, arready_q;
  logic [CW-1:0] q_count, q_count_nxt;
  logic [QW-1:0] q_head;

  assign ar_push     = s_axi.arvalid & arready_q;
  assign q_count_nxt = q_count + CW'(ar_push) - CW'(ar_pop);
  assign s_axi.arready = arready_q;

  tlk2711_sync_fifo #(.WIDTH(QW), .DEPTH(AR_DEPTH)) u_ar_q (
    .clk   (clk),
    .rst   (rst),
    .push  (ar_push),
    .din   ({s_axi.arid, s_axi.arlen}),
    .pop   (ar_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // arready looks one cycle ahead so a push can never land on a full queue
  always_ff @(posedge clk) begin
    if (!rst) arready_q <= 1'b1;
    else      arready_q <= (q_count_nxt != CW'(AR_DEPTH)) & ~q_full | (ar_pop & ~ar_push);
  end

  // ---------------- read FSM ----------------
  fsm_state_t            r_state;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [7:0]            cur_len, beat_cnt;
  logic [LW-1:0]         lat_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  r_hs, r_last;

  assign r_hs   = s_axi.rvalid & s_axi.rready;
  assign r_last = (beat_cnt == cur_len);
  assign ar_pop = ~q_empty & ((r_state == R_IDLE) | ((r_state == R_BURST) & r_hs & r_last));

  assign s_axi.rvalid = (r_state == R_BURST) & ~r_stall;
  assign s_axi.rlast  = (r_state == R_BURST) & r_last;
  assign s_axi.rid    = cur_id;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = AXI_RESP_OKAY;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= R_IDLE;
      cur_id     <= '0;
      cur_len    <= '0;
      beat_cnt   <= '0;
      lat_cnt    <= '0;
      rdata_q    <= DATA_INIT;
      o_rd_beats <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (!q_empty) begin
          {cur_id, cur_len} <= q_head;
          lat_cnt           <= LW'(RD_LATENCY - 1);
          r_state           <= R_WAIT;
        end
        R_WAIT: if (lat_cnt == '0) begin
          beat_cnt <= '0;
          r_state  <= R_BURST;
        end else begin
          lat_cnt <= lat_cnt - LW'(1);
        end
        R_BURST: if (r_hs) begin
          rdata_q    <= rdata_q + DATA_INC;
          o_rd_beats <= o_rd_beats + 32'd1;
          beat_cnt   <= beat_cnt + 8'd1;
          if (r_last) begin
            if (!q_empty) begin
              {cur_id, cur_len} <= q_head;
              lat_cnt           <= LW'(RD_LATENCY - 1);
              r_state           <= R_WAIT;
            end else begin
              r_state <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write FSM ----------------
  fsm_state_t          w_state;
  logic [ID_WIDTH-1:0] aw_id, bid_q;
  logic [7:0]          aw_len, w_cnt;
  logic                w_err, w_hs, w_bad;
  logic [1:0]          bresp_q;

  assign w_hs  = s_axi.wvalid & s_axi.wready;
  // early wlast, or the final beat arriving without wlast
  assign w_bad = s_axi.wlast ^ (w_cnt == aw_len);

  assign s_axi.awready = (w_state == W_IDLE);
  assign s_axi.wready  = (w_state == W_DATA) & ~w_stall;
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state    <= W_IDLE;
      aw_id      <= '0;
      aw_len     <= '0;
      w_cnt      <= '0;
      w_err      <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= AXI_RESP_OKAY;
      o_wr_beats <= '0;
      o_wr_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi.awvalid) begin
          aw_id   <= s_axi.awid;
          aw_len  <= s_axi.awlen;
          w_cnt   <= '0;
          w_err   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          o_wr_beats <= o_wr_beats + 32'd1;
          w_cnt      <= w_cnt + 8'd1;
          if (w_bad) begin
            w_err    <= 1'b1;
            o_wr_err <= 1'b1;
          end
          if (s_axi.wlast) begin
            bresp_q <= (w_err | w_bad) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            bid_q   <= aw_id;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (s_axi.bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlk2711_axi_mem_resp.sv
// Randomised self-checking bench for tlk2711_axi_mem_resp against a beat-level reference model.
module tb_tlk2711_axi_mem_resp;
  localparam int AW = 48, DW = 64, IW = 4, ARD = 4, RDL = 2;
  localparam logic [DW-1:0] D_INIT = 64'd1, D_INC = 64'd2;

  typedef struct { logic [IW-1:0] id; int len; } burst_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] rd_beats, wr_beats;
  logic wr_err;
  int n_checks = 0, n_pass = 0;

  // reference model state
  burst_t exp_q[$];
  int exp_beat = 0, exp_rd = 0, exp_wr = 0;
  logic [DW-1:0] exp_data = D_INIT;
  bit exp_err = 0;

  always #5 clk = ~clk;

  tlk2711_axi_mem_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s_axi ();

  tlk2711_axi_mem_resp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AR_DEPTH(ARD),
    .RD_LATENCY(RDL), .DATA_INIT(D_INIT), .DATA_INC(D_INC)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(s_axi),
    .o_rd_beats(rd_beats), .o_wr_beats(wr_beats), .o_wr_err(wr_err)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_beat = 0; exp_rd = 0; exp_wr = 0; exp_data = D_INIT; exp_err = 0;
  endtask

  task automatic issue_ar(input logic [IW-1:0] id, input int len);
    n_checks++;
    if (s_axi.arready !== 1'b1) $display("FAIL ar_ready_before_push: got %b want 1", s_axi.arready);
    else n_pass++;
    s_axi.arvalid = 1'b1; s_axi.arid = id; s_axi.arlen = 8'(len); s_axi.araddr = AW'($urandom);
    exp_q.push_back('{id: id, len: len});
    step();
    s_axi.arvalid = 1'b0;
  endtask

  // consume nbeats R beats, checking each accepted beat against the model
  task automatic collect(input int nbeats, input bit rand_rdy, input string tag);
    int got = 0, cyc = 0, idle = 0, bursts = 0;
    bit held = 0, rdy;
    logic [DW-1:0] h_data; logic [IW-1:0] h_id; logic h_last;
    while (got < nbeats && cyc < 4000) begin
      rdy = 1'b1;
      if (s_axi.rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++; $display("FAIL %s_unexpected_beat: got rdata %0h want no beat", tag, s_axi.rdata);
          break;
        end
        if (held) begin
          n_checks++;
          if ({s_axi.rdata, s_axi.rid, s_axi.rlast} !== {h_data, h_id, h_last})
            $display("FAIL %s_stable: got %0h/%0h/%b want %0h/%0h/%b", tag,
                     s_axi.rdata, s_axi.rid, s_axi.rlast, h_data, h_id, h_last);
          else n_pass++;
        end
`ifndef TLK_AXI_RAND_STALL_EN
        if (exp_beat == 0 && bursts > 0) begin
          n_checks++;
          if (idle !== RDL) $display("FAIL %s_gap: got %0d idle cycles want %0d", tag, idle, RDL);
          else n_pass++;
        end
`endif
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy) begin
          n_checks++;
          if (s_axi.rdata !== exp_data || s_axi.rid !== exp_q[0].id || s_axi.rresp !== 2'b00 ||
              s_axi.rlast !== (exp_beat == exp_q[0].len))
            $display("FAIL %s_beat: got d=%0h id=%0h resp=%0d last=%b want d=%0h id=%0h resp=0 last=%b",
                     tag, s_axi.rdata, s_axi.rid, s_axi.rresp, s_axi.rlast,
                     exp_data, exp_q[0].id, exp_beat == exp_q[0].len);
          else n_pass++;
          exp_data += D_INC; exp_rd++; got++; idle = 0; held = 0;
          if (exp_beat == exp_q[0].len) begin
            void'(exp_q.pop_front()); exp_beat = 0; bursts++;
          end else exp_beat++;
        end else begin
          held = 1; h_data = s_axi.rdata; h_id = s_axi.rid; h_last = s_axi.rlast;
        end
      end else idle++;
      s_axi.rready = rdy;
      step(); cyc++;
    end
    s_axi.rready = 1'b0;
    n_checks++;
    if (got != nbeats) $display("FAIL %s_timeout: got %0d beats want %0d", tag, got, nbeats);
    else n_pass++;
    n_checks++;
    if (rd_beats !== 32'(exp_rd)) $display("FAIL %s_rd_beats: got %0d want %0d", tag, rd_beats, exp_rd);
    else n_pass++;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input int awlen, input int nb, input string tag);
    int sent = 0, cyc = 0;
    bit bad = (nb != awlen + 1);
    n_checks++;
    if (s_axi.awready !== 1'b1) $display("FAIL %s_awready: got %b want 1", tag, s_axi.awready);
    else n_pass++;
    s_axi.awvalid = 1'b1; s_axi.awid = id; s_axi.awlen = 8'(awlen); s_axi.awaddr = AW'($urandom);
    step();
    s_axi.awvalid = 1'b0;
    while (sent < nb && cyc < 500) begin
      s_axi.wvalid = 1'b1; s_axi.wdata = {$urandom, $urandom}; s_axi.wstrb = '1;
      s_axi.wlast = (sent == nb - 1);
      if (s_axi.wready) sent++;
      step(); cyc++;
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    exp_wr += nb; exp_err |= bad;
    n_checks++;
    if (sent != nb || s_axi.bvalid !== 1'b1 || s_axi.bid !== id || s_axi.bresp !== (bad ? 2'b10 : 2'b00))
      $display("FAIL %s_bresp: got sent=%0d bvalid=%b bid=%0h bresp=%0d want sent=%0d 1 %0h %0d",
               tag, sent, s_axi.bvalid, s_axi.bid, s_axi.bresp, nb, id, bad ? 2 : 0);
    else n_pass++;
    n_checks++;
    if (wr_beats !== 32'(exp_wr) || wr_err !== exp_err)
      $display("FAIL %s_wr_count: got beats=%0d err=%b want %0d %b", tag, wr_beats, wr_err, exp_wr, exp_err);
    else n_pass++;
    s_axi.bready = 1'b1;
    step();
    s_axi.bready = 1'b0;
    n_checks++;
    if (s_axi.bvalid !== 1'b0 || s_axi.awready !== 1'b1)
      $display("FAIL %s_b_done: got bvalid=%b awready=%b want 0 1", tag, s_axi.bvalid, s_axi.awready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; step(); step();
    n_checks++;
    if ({s_axi.arready, s_axi.awready, s_axi.rvalid, s_axi.wready, s_axi.bvalid, s_axi.rlast} !== 6'b110000)
      $display("FAIL reset_handshake: got %b want 110000",
               {s_axi.arready, s_axi.awready, s_axi.rvalid, s_axi.wready, s_axi.bvalid, s_axi.rlast});
    else n_pass++;
    n_checks++;
    if ({s_axi.rresp, s_axi.bresp, s_axi.rid, s_axi.bid} !== '0 || s_axi.rdata !== D_INIT)
      $display("FAIL reset_values: got rresp=%0d bresp=%0d rid=%0h bid=%0h rdata=%0h want 0 0 0 0 %0h",
               s_axi.rresp, s_axi.bresp, s_axi.rid, s_axi.bid, s_axi.rdata, D_INIT);
    else n_pass++;
    n_checks++;
    if (rd_beats !== 0 || wr_beats !== 0 || wr_err !== 1'b0)
      $display("FAIL reset_counters: got %0d %0d %b want 0 0 0", rd_beats, wr_beats, wr_err);
    else n_pass++;
    rst = 1'b1; model_reset(); step();
  endtask

  task automatic test_single_read();
    int lat = 0;
    issue_ar(4'($urandom), 15);
    while (!s_axi.rvalid && lat < 50) begin step(); lat++; end
`ifndef TLK_AXI_RAND_STALL_EN
    n_checks++;
    if (lat != RDL + 1) $display("FAIL single_latency: got %0d cycles want %0d", lat, RDL + 1);
    else n_pass++;
`endif
    collect(16, 1'b0, "single");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) issue_ar(4'(i), 3);
    collect(16, 1'b0, "b2b");
  endtask

  task automatic test_stall_read();
    issue_ar(4'($urandom), 7);
    issue_ar(4'($urandom), $urandom_range(0, 5));
    collect(8 + exp_q[1].len + 1, 1'b1, "stall");
  endtask

  // with rready held low the head burst stalls and the queue behind it fills
  task automatic test_queue_full();
    int acc = 0, total = 0;
    for (int i = 0; i < 20; i++) begin
      if (!s_axi.arready) break;
      s_axi.arvalid = 1'b1; s_axi.arid = 4'($urandom);
      s_axi.arlen = (acc == 1) ? 8'd0 : 8'($urandom_range(0, 3));
      exp_q.push_back('{id: s_axi.arid, len: int'(s_axi.arlen)});
      total += int'(s_axi.arlen) + 1; acc++;
      step();
    end
    s_axi.arvalid = 1'b0;
    n_checks++;
    if (acc != ARD + 1 || s_axi.arready !== 1'b0)
      $display("FAIL qfull_accept: got %0d pushes arready=%b want %0d 0", acc, s_axi.arready, ARD + 1);
    else n_pass++;
    collect(total, 1'b0, "qfull");
  endtask

  task automatic test_w_without_aw();
    s_axi.wvalid = 1'b1; s_axi.wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (s_axi.wready !== 1'b0) $display("FAIL w_no_aw: got wready=%b want 0", s_axi.wready);
      else n_pass++;
      step();
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    n_checks++;
    if (wr_beats !== 32'(exp_wr)) $display("FAIL w_no_aw_count: got %0d want %0d", wr_beats, exp_wr);
    else n_pass++;
  endtask

  task automatic test_writes();
    int l;
    do_write(4'($urandom), 7, 8, "wr_ok");
    do_write(4'($urandom), 7, 5, "wr_short");
    do_write(4'($urandom), 3, 4, "wr_sticky");
    do_write(4'($urandom), 2, 5, "wr_long");
    for (int i = 0; i < 4; i++) begin
      l = $urandom_range(0, 10);
      do_write(4'($urandom), l, $urandom_range(0, 1) ? l + 1 : $urandom_range(1, 12), "wr_rand");
    end
  endtask

  task automatic test_concurrent();
    issue_ar(4'($urandom), 7);
    fork
      collect(8, 1'b1, "conc_rd");
      do_write(4'($urandom), 5, 6, "conc_wr");
    join
  endtask

  task automatic test_reset_mid_burst();
    issue_ar(4'($urandom), 15);
    s_axi.rready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b0; step();
    n_checks++;
    if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1 || s_axi.rdata !== D_INIT || rd_beats !== 0 || wr_err !== 1'b0)
      $display("FAIL mid_reset: got rvalid=%b arready=%b rdata=%0h beats=%0d err=%b want 0 1 %0h 0 0",
               s_axi.rvalid, s_axi.arready, s_axi.rdata, rd_beats, wr_err, D_INIT);
    else n_pass++;
    rst = 1'b1; s_axi.rready = 1'b0; model_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s_axi.rvalid !== 1'b0) $display("FAIL mid_reset_quiet: got rvalid=%b want 0", s_axi.rvalid);
      else n_pass++;
      step();
    end
    issue_ar(4'($urandom), 4);
    collect(5, 1'b0, "post_reset");
  endtask

  initial begin
    s_axi.arvalid = 0; s_axi.arid = 0; s_axi.araddr = 0; s_axi.arlen = 0; s_axi.rready = 0;
    s_axi.awvalid = 0; s_axi.awid = 0; s_axi.awaddr = 0; s_axi.awlen = 0;
    s_axi.wvalid = 0; s_axi.wdata = 0; s_axi.wstrb = 0; s_axi.wlast = 0; s_axi.bready = 0;
    step();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall_read();
    test_queue_full();
    test_w_without_aw();
    test_writes();
    test_concurrent();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
